// File: rtl/blk_mem_stream_ctrl.sv
// Frame-buffer controller: fills a blk_mem with DEPTH words, then drains them in address
// order through a 2-entry skid buffer that hides the memory's registered read latency.
module blk_mem_stream_ctrl #(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BIT_WIDTH-1:0]  s_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_in,
    output logic [BIT_WIDTH-1:0]  mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [BIT_WIDTH-1:0]  mem_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BIT_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic                  busy
);
    // One extra pointer bit so DEPTH == 2^ADDR_WIDTH is representable without aliasing.
    localparam int unsigned     PtrW    = ADDR_WIDTH + 1;
    localparam logic [PtrW-1:0] DepthP  = PtrW'(DEPTH);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      pop_cnt_q, pop_cnt_d;
    logic                 pend_q, pend_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] skid0_q, skid0_d;
    logic [BIT_WIDTH-1:0] skid1_q, skid1_d;
    logic                 in_hs, pop, push;
    logic [2:0]           occ_after_pop;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop_cnt_d = pop_cnt_q;
        cnt_d     = cnt_q;
        skid0_d   = skid0_q;
        skid1_d   = skid1_q;

        s_ready     = (state_q == StFill);
        busy        = (state_q == StDrain);
        in_hs       = s_valid && s_ready;
        mem_wr_en   = in_hs;
        mem_addr_in = wr_ptr_q[ADDR_WIDTH-1:0];
        mem_wr_data = s_data;

        m_valid = (cnt_q != 2'd0);
        m_data  = skid0_q;
        m_last  = m_valid && (pop_cnt_q == LastIdx);
        pop     = m_valid && m_ready;
        push    = pend_q;

        // Words held or in flight once this cycle's pop leaves; a new read needs room for one.
        occ_after_pop = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};
        mem_rd_en     = busy && (rd_ptr_q < DepthP) && (occ_after_pop < 3'd2);
        mem_addr_out  = rd_ptr_q[ADDR_WIDTH-1:0];
        pend_d        = mem_rd_en;

        if (state_q == StFill) begin
            if (in_hs) begin
                if (wr_ptr_q == LastIdx) begin
                    state_d  = StDrain;
                    wr_ptr_d = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
        end else begin
            if (mem_rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (pop) begin
                pop_cnt_d = pop_cnt_q + 1'b1;
                if (m_last) begin
                    state_d   = StFill;
                    rd_ptr_d  = '0;
                    pop_cnt_d = '0;
                    pend_d    = 1'b0;
                end
            end
        end

        case ({push, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    skid0_d = mem_rd_data;
                end else begin
                    skid1_d = mem_rd_data;
                end
            end
            2'b01: begin
                cnt_d   = cnt_q - 2'd1;
                skid0_d = skid1_q;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    skid0_d = mem_rd_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFill;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pop_cnt_q <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= 2'd0;
            skid0_q   <= '0;
            skid1_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pop_cnt_q <= pop_cnt_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            skid0_q   <= skid0_d;
            skid1_q   <= skid1_d;
        end
    end

    // A push into a full skid would silently drop a word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && cnt_q == 2'd2));

endmodule
